ro_measure_sequencer: RTL

//  Sequences one ring-oscillator frequency measurement: clears the INV/NAND/NOR/divider counters,

---
 rtl/ro_measure_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ro_measure_sequencer.sv
// ro_measure_sequencer
//   Runs one ring-oscillator frequency measurement: clears the RO counters,
//   lets the oscillators settle, opens a fixed-length count gate, waits for
//   the counter outputs to cross into data_clk, snapshots all four counts and
//   holds the snapshot for the serial framer until it is acknowledged.
//
// Ports
//   data_clk                          system clock, rising edge
//   reset                             asynchronous reset, active low
//   start                             one-cycle request for a measurement
//   continuous                        re-arm automatically after each handoff
//   abort                             drop the current measurement, go idle
//   inv/nand/nor/div_count [31:0]     RO counter values
//   frame_ack                         framer accepted the snapshot
//   ro_en                             oscillator enable
//   cnt_clear                         synchronous clear for the RO counters
//   cnt_gate                          count enable for the RO counters
//   snap_inv/nand/nor/div [31:0]      captured counts
//   snap_valid                        snapshot available until frame_ack
//   meas_id [7:0]                     number of the measurement in the snapshot
//   busy                              high in every state except IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start or continuous
// CLEAR   | one cycle: clear counters, enable oscillators
// SETTLE  | SETTLE_CYCLES cycles of oscillator start-up before counting
// GATE    | count gate open for GATE_CYCLES cycles
// SYNC    | SYNC_CYCLES cycles for the counter values to cross domains
// CAPTURE | one cycle: load snapshot registers, bump meas_id
// HANDOFF | oscillators off, snapshot held until frame_ack

module ro_measure_sequencer #(
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_CYCLES   = 3
) (
    input  logic        data_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic [31:0] inv_count,
    input  logic [31:0] nand_count,
    input  logic [31:0] nor_count,
    input  logic [31:0] div_count,
    input  logic        frame_ack,
    output logic        ro_en,
    output logic        cnt_clear,
    output logic        cnt_gate,
    output logic [31:0] snap_inv,
    output logic [31:0] snap_nand,
    output logic [31:0] snap_nor,
    output logic [31:0] snap_div,
    output logic        snap_valid,
    output logic [7:0]  meas_id,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_GATE,
        S_SYNC,
        S_CAPTURE,
        S_HANDOFF
    } state_t;

    // Timer is loaded with N-1 on entry so the state lasts exactly N cycles
    // and leaves on the terminal count of zero.
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LOAD   = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] SYNC_LOAD   = 32'(SYNC_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] timer, timer_nxt;
    logic        abort_hit;

    assign abort_hit = abort && (state != S_IDLE);

    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            S_IDLE: begin
                if (start || continuous) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                state_nxt = S_SETTLE;
                timer_nxt = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (timer == '0) begin
                    state_nxt = S_GATE;
                    timer_nxt = GATE_LOAD;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            S_GATE: begin
                if (timer == '0) begin
                    state_nxt = S_SYNC;
                    timer_nxt = SYNC_LOAD;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            S_SYNC: begin
                if (timer == '0) state_nxt = S_CAPTURE;
                else             timer_nxt = timer - 32'd1;
            end
            S_CAPTURE: begin
                state_nxt = S_HANDOFF;
            end
            S_HANDOFF: begin
                if (frame_ack) state_nxt = continuous ? S_CLEAR : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
        end
    end

    // Control outputs decode straight from the state so an asynchronous
    // reset takes them low immediately.
    always_comb begin
        ro_en     = 1'b0;
        cnt_clear = 1'b0;
        cnt_gate  = 1'b0;
        case (state)
            S_CLEAR: begin
                ro_en     = 1'b1;
                cnt_clear = 1'b1;
            end
            S_SETTLE, S_SYNC, S_CAPTURE: ro_en = 1'b1;
            S_GATE: begin
                ro_en    = 1'b1;
                cnt_gate = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Snapshot registers change only in CAPTURE, so they are stable for the
    // whole time snap_valid is high. An abort in CAPTURE discards the capture.
    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            snap_inv   <= '0;
            snap_nand  <= '0;
            snap_nor   <= '0;
            snap_div   <= '0;
            meas_id    <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (abort_hit) begin
                snap_valid <= 1'b0;
            end else if (state == S_CAPTURE) begin
                snap_inv   <= inv_count;
                snap_nand  <= nand_count;
                snap_nor   <= nor_count;
                snap_div   <= div_count;
                meas_id    <= meas_id + 8'd1;
                snap_valid <= 1'b1;
            end else if ((state == S_HANDOFF) && frame_ack) begin
                snap_valid <= 1'b0;
            end
        end
    end

endmodule
